regfile_mp_bypass: RTL and testbench
====================================

// Module: regfile_mp_bypass
// PURPOSE
//  Parametrised multi-port register file for the pipelined CPU.
//  - 2 combinational read ports (A = rs, B = rd).
//  - 2 write ports: WB and a second retire path.
//  - Write-to-read bypass: a read in the same cycle as a write to that address returns the new data.
//  - Per-register busy scoreboard: issue marks a register pending, writeback clears it.
//  - Flattened dump of all registers for the display/debug path.
// PARAMETERS
//  WIDTH      16  data width of each register
//  DEPTH       8  number of registers (power of 2, >=2)
//  AW          3  address width, = $clog2(DEPTH)
//  ZERO_REG    0  1: register 0 reads 0 and ignores writes and issue; 0: ordinary register
// PORTS
//  clock        in   1          rising-edge clock
//  reset        in   1          synchronous, active-high
//  rs           in   AW         read address, port A
//  rd           in   AW         read address, port B
//  ar           out  WIDTH      read data, port A (bypassed)
//  br           out  WIDTH      read data, port B (bypassed)
//  ar_busy      out  1          scoreboard bit of rs (after same-cycle clear)
//  br_busy      out  1          scoreboard bit of rd (after same-cycle clear)
//  we0          in   1          write enable, port 0
//  waddr0       in   AW         write address, port 0
//  wdata0       in   WIDTH      write data, port 0
//  we1          in   1          write enable, port 1
//  waddr1       in   AW         write address, port 1
//  wdata1       in   WIDTH      write data, port 1
//  issue_en     in   1          mark issue_addr pending
//  issue_addr   in   AW         destination register of the issued instruction
//  busy_vec     out  DEPTH      registered scoreboard, bit i = register i pending
//  regs_flat    out  DEPTH*WIDTH  register i occupies bits [i*WIDTH +: WIDTH]; registered values, no bypass
// BEHAVIOUR
//  Reset
//   - reset=1 at posedge: all registers <= 0, busy_vec <= 0.
//   - reset overrides same-cycle writes and issue.
//   - Comb outputs after reset: ar = br = 0, ar_busy = br_busy = 0.
//  Write (latency 1)
//   - weN=1: reg[waddrN] <= wdataN at posedge.
//   - we0 and we1 to the same address: port 1 wins.
//   - ZERO_REG=1: writes to address 0 are discarded.
//  Read (combinational, latency 0)
//   - ar = we1&&waddr1==rs ? wdata1 : we0&&waddr0==rs ? wdata0 : reg[rs]; br likewise with rd.
//   - ZERO_REG=1 and address 0: read data forced to 0, bypass included.
//  Scoreboard
//   - Next busy[i] = (busy[i] & ~clr[i]) | set[i].
//     - clr[i] = (we0 & waddr0==i) | (we1 & waddr1==i).
//     - set[i] = issue_en & issue_addr==i.
//   - Issue and writeback to the same register in one cycle: set wins, so the register stays busy
//     (a new producer is in flight).
//   - Issue to a register that is already busy: it stays busy (no counting; the pipeline stalls WAW).
//   - ar_busy = busy[rs] & ~clr[rs]; br_busy likewise with rd. Same-cycle issue is not visible until the next cycle.
//   - ZERO_REG=1: busy[0] is constant 0.
//  Width rules
//   - Addresses are AW bits. No out-of-range addresses when DEPTH = 2**AW.
//   - Data is stored unmodified, no extension.
//  Invariants
//   - Never X on outputs after the first reset.
//   - regs_flat and busy_vec change only at posedge.
// STRUCTURE
//  Shared package cpu_pkg
//   - Constants: REG_WIDTH=16, REG_DEPTH=8, REG_AW=3.
//   - Typedefs: reg_addr_t, reg_data_t.
//   - Function rf_bypass(): the 2-write priority-select used by both read ports.
//  Sub-module regfile_read_port (one instance per read port)
//   - Combinational array select, bypass compare, ZERO_REG masking and busy lookup.
//   - Parametrised with WIDTH, DEPTH, AW, ZERO_REG.
//  Top level: storage array, write decode and scoreboard update in a single always block.
// TESTING
//  1. Reset with all ports active
//     - Stimulus: reset=1 while we0=1 (waddr0=3, wdata0=16'h1234) and issue_en=1.
//     - Required: next cycle regs_flat == 0 and busy_vec == 0.
//  2. Write then read, plus bypass
//     - Stimulus: we0=1, waddr0=5, wdata0=16'hBEEF, rs=5.
//     - Required: ar=16'hBEEF in the same cycle; next cycle with we0=0, ar=16'hBEEF from storage.
//  3. Dual-write collision
//     - Stimulus: we0 writes 16'h1111 and we1 writes 16'h2222, both to address 2, rd=2.
//     - Required: br=16'h2222 in the same cycle; reg2=16'h2222 afterwards.
//  4. Scoreboard
//     - Stimulus: issue_addr=4 issued.
//     - Required: busy_vec[4]=1 next cycle.
//     - Stimulus: we1 to address 4 with rs=4.
//     - Required: ar_busy=0 in the same cycle; busy_vec[4]=0 next cycle.
//     - Stimulus: issue and we0 to address 4 in the same cycle.
//     - Required: busy_vec[4] stays 1.
//  5. ZERO_REG=1
//     - Stimulus: we0 writes 16'hFFFF to address 0, issue to 0, rs=0.
//     - Required: ar=0 and busy_vec[0]=0 at all times.
//  6. Random regression
//     - Stimulus: 10k cycles of random ports.
//     - Required: ar, br, busy and regs_flat match a behavioural model every cycle,
//       at DEPTH=8/WIDTH=16 and DEPTH=32/WIDTH=32.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared register-file constants, data/address typedefs and the
//                two-write bypass priority-select used by every read port.
//  Contents    : REG_WIDTH / REG_DEPTH / REG_AW   default register-file geometry
//                reg_addr_t / reg_data_t           default-width address/data
//                byp_sel_e                         read-port source select
//                rf_bypass()                       write-to-read priority select
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_WIDTH = 16;
    localparam int REG_DEPTH = 8;
    localparam int REG_AW    = 3;

    typedef logic [REG_AW-1:0]    reg_addr_t;
    typedef logic [REG_WIDTH-1:0] reg_data_t;

    // Source of a read port's data: the stored register or one of the two
    // write ports currently targeting the same address.
    typedef enum logic [1:0] {
        BYP_REG = 2'd0,
        BYP_W0  = 2'd1,
        BYP_W1  = 2'd2
    } byp_sel_e;

    // The select is returned instead of the data itself so that one helper
    // serves register files of any data width. Port 1 has priority, which
    // matches the storage update where the port 1 write lands last.
    function automatic byp_sel_e rf_bypass(input logic hit0, input logic hit1);
        byp_sel_e sel;
        if (hit1) begin
            sel = BYP_W1;
        end else if (hit0) begin
            sel = BYP_W0;
        end else begin
            sel = BYP_REG;
        end
        return sel;
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : One combinational read port of the multi-port register file.
//                Selects the addressed register, forwards same-cycle write data
//                (port 1 over port 0), masks register 0 when it is hard-wired
//                to zero, and reports the scoreboard bit with same-cycle
//                writeback already applied.
//  Ports       : addr        read address
//                regs_flat   all stored registers, reg i at [i*WIDTH +: WIDTH]
//                busy        registered scoreboard vector
//                we0/waddr0/wdata0, we1/waddr1/wdata1   current write ports
//                rdata       bypassed read data
//                rbusy       busy bit of addr after same-cycle clear
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_read_port #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int ZERO_REG = 0
) (
    input  logic [AW-1:0]          addr,
    input  logic [DEPTH*WIDTH-1:0] regs_flat,
    input  logic [DEPTH-1:0]       busy,
    input  logic                   we0,
    input  logic [AW-1:0]          waddr0,
    input  logic [WIDTH-1:0]       wdata0,
    input  logic                   we1,
    input  logic [AW-1:0]          waddr1,
    input  logic [WIDTH-1:0]       wdata1,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rbusy
);
    import cpu_pkg::*;

    logic             w_hit0;
    logic             w_hit1;
    logic             w_zero_addr;
    byp_sel_e         w_sel;
    logic [WIDTH-1:0] w_stored;

    assign w_hit0   = we0 && (waddr0 == addr);
    assign w_hit1   = we1 && (waddr1 == addr);
    assign w_sel    = rf_bypass(w_hit0, w_hit1);
    assign w_stored = regs_flat[int'(addr)*WIDTH +: WIDTH];

    // Register 0 is only special when the file is built with a zero register;
    // otherwise the mask term is tied off and disappears.
    if (ZERO_REG != 0) begin : g_zero_reg
        assign w_zero_addr = (addr == '0);
    end else begin : g_plain_reg
        assign w_zero_addr = 1'b0;
    end

    always_comb begin
        rdata = w_stored;
        case (w_sel)
            BYP_W1:  rdata = wdata1;
            BYP_W0:  rdata = wdata0;
            default: rdata = w_stored;
        endcase
        // The zero mask sits after the bypass so forwarded writes to r0 are
        // hidden as well.
        if (w_zero_addr) begin
            rdata = '0;
        end

        // A writeback in this cycle retires the producer, so a consumer may
        // already treat the operand as ready. Same-cycle issue is not folded
        // in: it only becomes visible once the scoreboard has registered it.
        rbusy = busy[addr] & ~(w_hit0 | w_hit1) & ~w_zero_addr;
    end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile_mp_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_bypass
//  Description : Parametrised multi-port register file for the pipelined CPU.
//                Two combinational read ports with write-to-read bypass, two
//                write ports (WB and a second retire path, port 1 wins on an
//                address collision), a per-register busy scoreboard and a
//                flattened dump of the stored registers.
//  Ports       : clock, reset              rising-edge clock, sync active-high
//                rs / ar / ar_busy         read port A address, data, busy
//                rd / br / br_busy         read port B address, data, busy
//                we0, waddr0, wdata0       write port 0
//                we1, waddr1, wdata1       write port 1
//                issue_en, issue_addr      mark a destination register pending
//                busy_vec                  registered scoreboard
//                regs_flat                 registered contents, reg i at
//                                          [i*WIDTH +: WIDTH], no bypass
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_mp_bypass
    import cpu_pkg::*;
#(
    parameter int WIDTH    = REG_WIDTH,
    parameter int DEPTH    = REG_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [AW-1:0]          rs,
    input  logic [AW-1:0]          rd,
    output logic [WIDTH-1:0]       ar,
    output logic [WIDTH-1:0]       br,
    output logic                   ar_busy,
    output logic                   br_busy,
    input  logic                   we0,
    input  logic [AW-1:0]          waddr0,
    input  logic [WIDTH-1:0]       wdata0,
    input  logic                   we1,
    input  logic [AW-1:0]          waddr1,
    input  logic [WIDTH-1:0]       wdata1,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_addr,
    output logic [DEPTH-1:0]       busy_vec,
    output logic [DEPTH*WIDTH-1:0] regs_flat
);

    // Packed storage so the debug dump is a plain view of the flops.
    logic [DEPTH-1:0][WIDTH-1:0] regs_q;
    logic [DEPTH-1:0][WIDTH-1:0] regs_d;
    logic [DEPTH-1:0]            busy_q;
    logic [DEPTH-1:0]            busy_d;
    logic [DEPTH-1:0]            w_clr;
    logic [DEPTH-1:0]            w_set;

    // ------------------------------------------------------------------
    // Write decode and scoreboard next state
    // ------------------------------------------------------------------
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_clr[i] = (we0 && (waddr0 == AW'(i))) || (we1 && (waddr1 == AW'(i)));
            w_set[i] = issue_en && (issue_addr == AW'(i));
        end

        // Port 1 is applied last so it wins a same-address collision.
        regs_d = regs_q;
        if (we0) begin
            regs_d[waddr0] = wdata0;
        end
        if (we1) begin
            regs_d[waddr1] = wdata1;
        end

        // Set after clear: an issue landing with a writeback to the same
        // register means a newer producer is in flight, so it stays busy.
        // No counting of repeated issues; the pipeline stalls on WAW.
        busy_d = (busy_q & ~w_clr) | w_set;

        if (ZERO_REG != 0) begin
            regs_d[0] = '0;
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign busy_vec  = busy_q;
    assign regs_flat = regs_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    regfile_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .addr      (rs),
        .regs_flat (regs_q),
        .busy      (busy_q),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .rdata     (ar),
        .rbusy     (ar_busy)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .addr      (rd),
        .regs_flat (regs_q),
        .busy      (busy_q),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .rdata     (br),
        .rbusy     (br_busy)
    );

endmodule : regfile_mp_bypass
`default_nettype wire

// File: tb/tb_regfile_mp_bypass.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp_bypass
//  Description : Self-checking bench for regfile_mp_bypass. Three instances
//                share one stimulus stream: 8x16 ordinary, 8x16 with a zero
//                register, and 32x32 ordinary. A behavioural model of each
//                instance (plain arrays) predicts every output, a compare
//                process checks all instances each cycle, and directed
//                sequences pin key values with literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_mp_bypass;

    logic        clock;
    logic        reset;
    logic [4:0]  rs, rd, waddr0, waddr1, issue_addr;
    logic [31:0] wdata0, wdata1;
    logic        we0, we1, issue_en;

    logic [15:0]   ar0, br0, ar1, br1;
    logic [31:0]   ar2, br2;
    logic          arb0, brb0, arb1, brb1, arb2, brb2;
    logic [7:0]    bv0, bv1;
    logic [31:0]   bv2;
    logic [127:0]  flat0, flat1;
    logic [1023:0] flat2;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    logic [31:0] m_regs [3][32];
    bit          m_busy [3][32];

    logic [31:0] d_ar [3];
    logic [31:0] d_br [3];
    logic        d_arb [3];
    logic        d_brb [3];
    logic [31:0] d_bv [3];
    logic [31:0] d_reg [3][32];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    regfile_mp_bypass #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(0)) u_rf0 (
        .clock(clock), .reset(reset), .rs(rs[2:0]), .rd(rd[2:0]),
        .ar(ar0), .br(br0), .ar_busy(arb0), .br_busy(brb0),
        .we0(we0), .waddr0(waddr0[2:0]), .wdata0(wdata0[15:0]),
        .we1(we1), .waddr1(waddr1[2:0]), .wdata1(wdata1[15:0]),
        .issue_en(issue_en), .issue_addr(issue_addr[2:0]),
        .busy_vec(bv0), .regs_flat(flat0)
    );

    regfile_mp_bypass #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(1)) u_rf1 (
        .clock(clock), .reset(reset), .rs(rs[2:0]), .rd(rd[2:0]),
        .ar(ar1), .br(br1), .ar_busy(arb1), .br_busy(brb1),
        .we0(we0), .waddr0(waddr0[2:0]), .wdata0(wdata0[15:0]),
        .we1(we1), .waddr1(waddr1[2:0]), .wdata1(wdata1[15:0]),
        .issue_en(issue_en), .issue_addr(issue_addr[2:0]),
        .busy_vec(bv1), .regs_flat(flat1)
    );

    regfile_mp_bypass #(.WIDTH(32), .DEPTH(32), .AW(5), .ZERO_REG(0)) u_rf2 (
        .clock(clock), .reset(reset), .rs(rs), .rd(rd),
        .ar(ar2), .br(br2), .ar_busy(arb2), .br_busy(brb2),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_vec(bv2), .regs_flat(flat2)
    );

    // Gather the three instances into uniform 32-bit views.
    always_comb begin
        d_ar[0] = {16'h0, ar0};  d_ar[1] = {16'h0, ar1};  d_ar[2] = ar2;
        d_br[0] = {16'h0, br0};  d_br[1] = {16'h0, br1};  d_br[2] = br2;
        d_arb[0] = arb0; d_arb[1] = arb1; d_arb[2] = arb2;
        d_brb[0] = brb0; d_brb[1] = brb1; d_brb[2] = brb2;
        d_bv[0] = {24'h0, bv0};  d_bv[1] = {24'h0, bv1};  d_bv[2] = bv2;
        for (int i = 0; i < 32; i++) begin
            d_reg[0][i] = '0;
            d_reg[1][i] = '0;
            d_reg[2][i] = flat2[i*32 +: 32];
        end
        for (int i = 0; i < 8; i++) begin
            d_reg[0][i] = {16'h0, flat0[i*16 +: 16]};
            d_reg[1][i] = {16'h0, flat1[i*16 +: 16]};
        end
    end

    // ---------------- instance configuration ----------------
    function automatic int cfg_depth(int k);
        return (k == 2) ? 32 : 8;
    endfunction
    function automatic int cfg_width(int k);
        return (k == 2) ? 32 : 16;
    endfunction
    function automatic bit cfg_zero(int k);
        return (k == 1);
    endfunction
    function automatic logic [31:0] dmask(int k);
        return (cfg_width(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_width(k)) - 32'd1);
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] exp_data(int k, logic [4:0] addr);
        int a, a0, a1;
        a  = int'(addr)   % cfg_depth(k);
        a0 = int'(waddr0) % cfg_depth(k);
        a1 = int'(waddr1) % cfg_depth(k);
        if (cfg_zero(k) && a == 0) return '0;
        if (we1 && a1 == a) return wdata1 & dmask(k);
        if (we0 && a0 == a) return wdata0 & dmask(k);
        return m_regs[k][a];
    endfunction

    function automatic logic exp_busy(int k, logic [4:0] addr);
        int a, a0, a1;
        a  = int'(addr)   % cfg_depth(k);
        a0 = int'(waddr0) % cfg_depth(k);
        a1 = int'(waddr1) % cfg_depth(k);
        if (cfg_zero(k) && a == 0) return 1'b0;
        if ((we0 && a0 == a) || (we1 && a1 == a)) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [31:0] exp_bv(int k);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < cfg_depth(k); i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    task automatic model_update();
        int a0, a1, ai;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    m_regs[k][i] = '0;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                a0 = int'(waddr0)     % cfg_depth(k);
                a1 = int'(waddr1)     % cfg_depth(k);
                ai = int'(issue_addr) % cfg_depth(k);
                if (we0 && !(cfg_zero(k) && a0 == 0)) m_regs[k][a0] = wdata0 & dmask(k);
                if (we1 && !(cfg_zero(k) && a1 == 0)) m_regs[k][a1] = wdata1 & dmask(k);
                if (we0) m_busy[k][a0] = 1'b0;
                if (we1) m_busy[k][a1] = 1'b0;
                if (issue_en && !(cfg_zero(k) && ai == 0)) m_busy[k][ai] = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%h expected=%h at t=%0t", name, k, got, exp, $time);
        end
    endtask

    // Model advances on every rising edge, using the inputs present there.
    initial begin
        forever begin
            @(posedge clock);
            model_update();
        end
    end

    // Compare process: every falling edge once the first reset is done.
    initial begin
        int bad;
        forever begin
            @(negedge clock);
            if (chk_en) begin
                for (int k = 0; k < 3; k++) begin
                    check("ar", k, d_ar[k], exp_data(k, rs));
                    check("br", k, d_br[k], exp_data(k, rd));
                    check("ar_busy", k, {31'b0, d_arb[k]}, {31'b0, exp_busy(k, rs)});
                    check("br_busy", k, {31'b0, d_brb[k]}, {31'b0, exp_busy(k, rd)});
                    check("busy_vec", k, d_bv[k], exp_bv(k));
                    bad = 0;
                    for (int i = cfg_depth(k) - 1; i >= 0; i--) begin
                        if (d_reg[k][i] !== m_regs[k][i]) bad = i;
                    end
                    check($sformatf("regs_flat[%0d]", bad), k, d_reg[k][bad], m_regs[k][bad]);
                end
            end
        end
    end

    task automatic idle();
        reset = 1'b0; we0 = 1'b0; we1 = 1'b0; issue_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        rs = '0; rd = '0; waddr0 = '0; waddr1 = '0; issue_addr = '0;
        wdata0 = '0; wdata1 = '0;

        // 1. Reset with write and issue active
        reset = 1'b1; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1234;
        issue_en = 1'b1; issue_addr = 5'd3;
        tick();
        idle();
        chk_en = 1'b1;
        @(negedge clock);
        check("t1 reg3", 0, d_reg[0][3], 32'h0);
        check("t1 busy_vec", 0, d_bv[0], 32'h0);
        check("t1 busy_vec", 2, d_bv[2], 32'h0);
        check("t1 ar", 0, d_ar[0], 32'h0);

        // 2. Write with bypass, then read from storage
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h0000_BEEF; rs = 5'd5;
        @(negedge clock);
        check("t2 bypass ar", 0, d_ar[0], 32'h0000_BEEF);
        tick();
        idle();
        @(negedge clock);
        check("t2 stored ar", 0, d_ar[0], 32'h0000_BEEF);
        check("t2 model reg5", 0, m_regs[0][5], 32'h0000_BEEF);

        // 3. Dual-write collision, port 1 wins
        we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h1111;
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h2222; rd = 5'd2;
        @(negedge clock);
        check("t3 bypass br", 0, d_br[0], 32'h2222);
        tick();
        idle();
        @(negedge clock);
        check("t3 reg2", 0, d_reg[0][2], 32'h2222);
        check("t3 reg2", 2, d_reg[2][2], 32'h2222);

        // 4. Scoreboard set, same-cycle clear, set-wins
        issue_en = 1'b1; issue_addr = 5'd4;
        tick();
        idle();
        rs = 5'd4;
        @(negedge clock);
        check("t4 busy4 set", 0, {31'b0, d_bv[0][4]}, 32'd1);
        check("t4 ar_busy held", 0, {31'b0, d_arb[0]}, 32'd1);
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h4444;
        @(negedge clock);
        check("t4 ar_busy cleared", 0, {31'b0, d_arb[0]}, 32'd0);
        tick();
        idle();
        @(negedge clock);
        check("t4 busy4 clr", 0, {31'b0, d_bv[0][4]}, 32'd0);
        issue_en = 1'b1; issue_addr = 5'd4; we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h5555;
        tick();
        idle();
        @(negedge clock);
        check("t4 busy4 set wins", 0, {31'b0, d_bv[0][4]}, 32'd1);
        check("t4 busy4 set wins", 2, {31'b0, d_bv[2][4]}, 32'd1);

        // 5. Zero register (instance 1) vs ordinary r0 (instance 0)
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h0000_FFFF;
        issue_en = 1'b1; issue_addr = 5'd0; rs = 5'd0;
        @(negedge clock);
        check("t5 zero ar", 1, d_ar[1], 32'h0);
        check("t5 plain ar", 0, d_ar[0], 32'h0000_FFFF);
        tick();
        @(negedge clock);
        check("t5 zero ar held", 1, d_ar[1], 32'h0);
        check("t5 zero busy0", 1, {31'b0, d_bv[1][0]}, 32'd0);
        check("t5 plain busy0", 0, {31'b0, d_bv[0][0]}, 32'd1);
        tick();
        idle();
        @(negedge clock);
        check("t5 zero reg0", 1, d_reg[1][0], 32'h0);
        check("t5 zero busy0", 1, {31'b0, d_bv[1][0]}, 32'd0);
        check("t5 plain reg0", 0, d_reg[0][0], 32'h0000_FFFF);
        tick();

        // 6. Random regression
        for (int n = 0; n < 10000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            we0        = 1'($urandom_range(0, 1));
            we1        = 1'($urandom_range(0, 1));
            issue_en   = 1'($urandom_range(0, 1));
            rs         = 5'($urandom_range(0, 31));
            rd         = 5'($urandom_range(0, 31));
            waddr0     = 5'($urandom_range(0, 31));
            waddr1     = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom_range(0, 31));
            issue_addr = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rs = waddr1;
            if ($urandom_range(0, 3) == 0) rd = waddr0;
            wdata0     = $urandom;
            wdata1     = $urandom;
            tick();
        end

        idle();
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_mp_bypass
`default_nettype wire
